// File: rtl/sample_frame_collector_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_frame_collector_if
// Purpose  : Bundles the sample stream (valid/ready/last) and the parallel
//            frame output (valid/ready/len) of the sample frame collector.
//            master = sample source / frame sink, slave = collector.
// Revision : 1.0 - initial release
// ============================================================================
interface sample_frame_collector_if #(
  parameter int FFT_POINTS = 16,
  parameter int DATA_WIDTH = 30
);
  localparam int LEN_W = $clog2(FFT_POINTS) + 1;

  logic [DATA_WIDTH-1:0]                 s_data;
  logic                                  s_valid;
  logic                                  s_ready;
  logic                                  s_last;
  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] frame_data;
  logic                                  frame_valid;
  logic                                  frame_ready;
  logic [LEN_W-1:0]                      frame_len;

  modport master (
    output s_data, s_valid, s_last, frame_ready,
    input  s_ready, frame_data, frame_valid, frame_len
  );

  modport slave (
    input  s_data, s_valid, s_last, frame_ready,
    output s_ready, frame_data, frame_valid, frame_len
  );
endinterface
`default_nettype wire

// File: rtl/sample_frame_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sample_frame_collector
// Purpose  : Packs a valid/ready sample stream into an FFT_POINTS-wide frame.
//            Capture bank fills while the output bank holds the previous
//            frame; short frames (s_last) are zero-filled.
// Options  : FRAME_ZERO_PAD_EN - capture only FFT_POINTS/2 samples per frame,
//            upper half of every frame is zero.
// Revision : 1.0 - initial release
// ============================================================================
module sample_frame_collector #(
  parameter int FFT_POINTS = 16,
  parameter int DATA_WIDTH = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  sample_frame_collector_if.slave    sfc
);

  localparam int IDX_W = $clog2(FFT_POINTS);
  localparam int LEN_W = IDX_W + 1;
`ifdef FRAME_ZERO_PAD_EN
  localparam int N_IN  = FFT_POINTS / 2;
`else
  localparam int N_IN  = FFT_POINTS;
`endif

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t                                state_q;
  logic [IDX_W-1:0]                      wr_idx_q;
  logic [N_IN-1:0][DATA_WIDTH-1:0]       cap_q;
  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] frame_data_q;
  logic                                  frame_valid_q;
  logic [LEN_W-1:0]                      frame_len_q;

  logic                                  accept_d;
  logic                                  complete_d;
  logic                                  out_free_d;
  logic [LEN_W-1:0]                      frame_len_d;
  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] fill_frame_d;
  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] full_frame_d;

  // Ready is held low during reset so no sample slips in while rst_n is low.
  assign sfc.s_ready     = rst_n & (state_q == ST_FILL);
  assign sfc.frame_data  = frame_data_q;
  assign sfc.frame_valid = frame_valid_q;
  assign sfc.frame_len   = frame_len_q;

  assign accept_d    = sfc.s_valid & sfc.s_ready;
  assign complete_d  = accept_d & (sfc.s_last | (wr_idx_q == IDX_W'(N_IN - 1)));
  assign out_free_d  = ~frame_valid_q | sfc.frame_ready;
  assign frame_len_d = LEN_W'(wr_idx_q) + LEN_W'(1);

  // Candidate output frames: direct bypass (incoming sample lands at wr_idx)
  // and drain from a full capture bank; slots past the last real sample are 0.
  always_comb begin
    fill_frame_d = '0;
    full_frame_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (IDX_W'(i) < wr_idx_q) begin
        fill_frame_d[i] = cap_q[i];
      end else if (IDX_W'(i) == wr_idx_q) begin
        fill_frame_d[i] = sfc.s_data;
      end
      if (IDX_W'(i) <= wr_idx_q) begin
        full_frame_d[i] = cap_q[i];
      end
    end
  end

  // Collector FSM: capture samples, hand frames to the output bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_FILL;
      wr_idx_q      <= '0;
      cap_q         <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
    end else begin
      // Consumed frame drops valid unless a transfer below refills it.
      if (frame_valid_q && sfc.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
      case (state_q)
        ST_FILL: begin
          if (accept_d) begin
            if (complete_d && out_free_d) begin
              frame_data_q  <= fill_frame_d;
              frame_len_q   <= frame_len_d;
              frame_valid_q <= 1'b1;
              wr_idx_q      <= '0;
            end else begin
              for (int i = 0; i < N_IN; i++) begin
                if (IDX_W'(i) == wr_idx_q) begin
                  cap_q[i] <= sfc.s_data;
                end
              end
              // wr_idx stays on the last sample in FULL so it encodes the count.
              if (complete_d) begin
                state_q <= ST_FULL;
              end else begin
                wr_idx_q <= wr_idx_q + IDX_W'(1);
              end
            end
          end
        end
        ST_FULL: begin
          if (sfc.frame_ready) begin
            frame_data_q  <= full_frame_d;
            frame_len_q   <= frame_len_d;
            frame_valid_q <= 1'b1;
            wr_idx_q      <= '0;
            state_q       <= ST_FILL;
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_frame_collector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sample_frame_collector
// Purpose  : Self-checking bench for sample_frame_collector. Expected frames
//            are built from the accepted samples and queued; a monitor pops
//            and compares them at every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sample_frame_collector;

  localparam int FFT_POINTS = 16;
  localparam int DATA_WIDTH = 30;
  localparam int LEN_W      = $clog2(FFT_POINTS) + 1;
`ifdef FRAME_ZERO_PAD_EN
  localparam int N_IN       = FFT_POINTS / 2;
`else
  localparam int N_IN       = FFT_POINTS;
`endif

  typedef struct packed {
    logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] data;
    logic [LEN_W-1:0]                      len;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sample_frame_collector_if #(.FFT_POINTS(FFT_POINTS), .DATA_WIDTH(DATA_WIDTH)) sfc ();

  sample_frame_collector #(.FFT_POINTS(FFT_POINTS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sfc   (sfc)
  );

  int                    tests = 0;
  int                    fails = 0;
  frame_t                sb[$];
  frame_t                mon_exp;
  logic [DATA_WIDTH-1:0] mbuf [FFT_POINTS];
  int                    mcnt = 0;

  // Output monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && sfc.frame_valid && sfc.frame_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL frame_unexpected: got frame len=%0d, required no frame", sfc.frame_len);
      end else begin
        mon_exp = sb.pop_front();
        if (sfc.frame_data !== mon_exp.data) begin
          fails++;
          $display("FAIL frame_data: got %h required %h", sfc.frame_data, mon_exp.data);
        end
        tests++;
        if (sfc.frame_len !== mon_exp.len) begin
          fails++;
          $display("FAIL frame_len: got %0d required %0d", sfc.frame_len, mon_exp.len);
        end
      end
    end
  end

  // Present one sample until accepted; record it in the reference model.
  task automatic send(input logic [DATA_WIDTH-1:0] d, input logic lst);
    logic   rdy;
    int     n;
    frame_t f;
    sfc.s_data  = d;
    sfc.s_valid = 1'b1;
    sfc.s_last  = lst;
    n = 0;
    do begin
      @(negedge clk);
      rdy = sfc.s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 64);
    if (!rdy) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: sample %0d s_ready=%b, required 1", d, rdy);
    end else begin
      mbuf[mcnt] = d;
      mcnt++;
      if (lst || mcnt == N_IN) begin
        f.data = '0;
        for (int k = 0; k < mcnt; k++) f.data[k] = mbuf[k];
        f.len = LEN_W'(mcnt);
        sb.push_back(f);
        mcnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    sfc.s_valid = 1'b0;
    sfc.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (sfc.s_ready !== 1'b0)     begin fails++; $display("FAIL reset_s_ready: got %b required 0", sfc.s_ready); end
    tests++; if (sfc.frame_valid !== 1'b0) begin fails++; $display("FAIL reset_frame_valid: got %b required 0", sfc.frame_valid); end
    tests++; if (sfc.frame_len !== '0)     begin fails++; $display("FAIL reset_frame_len: got %0d required 0", sfc.frame_len); end
    tests++; if (sfc.frame_data !== '0)    begin fails++; $display("FAIL reset_frame_data: got %h required 0", sfc.frame_data); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_full_frame();
    sfc.frame_ready = 1'b1;
    for (int i = 1; i <= N_IN; i++) begin
      send(DATA_WIDTH'(i), 1'b0);
      if (i == N_IN - 1) begin
        tests++;
        if (sfc.frame_valid !== 1'b0) begin fails++; $display("FAIL full_early_valid: got %b required 0", sfc.frame_valid); end
      end
    end
    tests++;
    if (sfc.frame_valid !== 1'b1) begin fails++; $display("FAIL full_valid_latency: got %b required 1", sfc.frame_valid); end
    idle(2);
  endtask

  task automatic test_short_frame();
    sfc.frame_ready = 1'b1;
    for (int i = 10; i <= 14; i++) begin
      send(DATA_WIDTH'(i), i == 14);
      tests++;
      if (sfc.s_ready !== 1'b1) begin fails++; $display("FAIL short_s_ready: after %0d got %b required 1", i, sfc.s_ready); end
    end
    idle(2);
  endtask

  task automatic test_hold();
    sfc.frame_ready = 1'b0;
    for (int i = 1; i <= N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    for (int i = 101; i <= 100 + N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    sfc.s_valid = 1'b0;
    tests++;
    if (sfc.s_ready !== 1'b0) begin fails++; $display("FAIL hold_s_ready_full: got %b required 0", sfc.s_ready); end
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (sfc.frame_valid !== 1'b1) begin fails++; $display("FAIL hold_valid: got %b required 1", sfc.frame_valid); end
      tests++;
      if (sfc.frame_data !== sb[0].data) begin fails++; $display("FAIL hold_data: got %h required %h", sfc.frame_data, sb[0].data); end
      tests++;
      if (sfc.frame_len !== sb[0].len) begin fails++; $display("FAIL hold_len: got %0d required %0d", sfc.frame_len, sb[0].len); end
    end
    @(posedge clk);
    #1 sfc.frame_ready = 1'b1;
    @(posedge clk);
    #1 sfc.frame_ready = 1'b0;
    tests++;
    if (sfc.frame_valid !== 1'b1) begin fails++; $display("FAIL hold_next_valid: got %b required 1", sfc.frame_valid); end
    tests++;
    if (sfc.s_ready !== 1'b1) begin fails++; $display("FAIL hold_s_ready_refill: got %b required 1", sfc.s_ready); end
    tests++;
    if (sfc.frame_data !== sb[0].data) begin fails++; $display("FAIL hold_next_data: got %h required %h", sfc.frame_data, sb[0].data); end
    sfc.frame_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_mid();
    sfc.frame_ready = 1'b0;
    for (int i = 51; i <= 50 + N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    for (int i = 71; i <= 77; i++) send(DATA_WIDTH'(i), 1'b0);
    sfc.s_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (sfc.frame_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b required 0", sfc.frame_valid); end
    tests++; if (sfc.frame_data !== '0)    begin fails++; $display("FAIL rstmid_data: got %h required 0", sfc.frame_data); end
    tests++; if (sfc.frame_len !== '0)     begin fails++; $display("FAIL rstmid_len: got %0d required 0", sfc.frame_len); end
    tests++; if (sfc.s_ready !== 1'b0)     begin fails++; $display("FAIL rstmid_s_ready: got %b required 0", sfc.s_ready); end
    sb.delete();
    mcnt = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sfc.frame_ready = 1'b1;
    for (int i = 201; i <= 200 + N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    idle(2);
  endtask

`ifdef FRAME_ZERO_PAD_EN
  task automatic test_zero_pad();
    sfc.frame_ready = 1'b1;
    for (int i = 1; i <= N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    for (int i = 1; i <= 3; i++) send(DATA_WIDTH'(i), i == 3);
    idle(2);
  endtask
`endif

  task automatic test_back_to_back();
    sfc.frame_ready = 1'b0;
    for (int i = 301; i <= 300 + N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    for (int i = 401; i < 400 + N_IN; i++) send(DATA_WIDTH'(i), 1'b0);
    sfc.frame_ready = 1'b1;
    send(DATA_WIDTH'(400 + N_IN), 1'b0);
    tests++;
    if (sfc.frame_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid: got %b required 1", sfc.frame_valid); end
    tests++;
    if (sfc.s_ready !== 1'b1) begin fails++; $display("FAIL b2b_s_ready: got %b required 1", sfc.s_ready); end
    idle(3);
  endtask

  initial begin
    sfc.s_data      = '0;
    sfc.s_valid     = 1'b0;
    sfc.s_last      = 1'b0;
    sfc.frame_ready = 1'b0;
    test_reset();
    test_full_frame();
    test_short_frame();
    test_hold();
    test_reset_mid();
`ifdef FRAME_ZERO_PAD_EN
    test_zero_pad();
`endif
    test_back_to_back();
    idle(3);
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL frames_outstanding: got %0d required 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
